glb_load_scheduler: RTL

Sequences DRAM-to-GLB loading for one layer pass. Accepts a 32-bit beat stream over a valid/ready handshake. Routes beats in a fixed order (ifmap, then weight, then bias) into the three input SRAMs, generating each SRAM's write enable, address and data. Then pulses the compute start to the array/PPU controller and waits for its completion, sitting between the DRAM interface and the existing controller.

---
 rtl/glb_load_pkg.sv | 24 ++
 rtl/glb_load_scheduler_if.sv | 37 +++
 rtl/glb_section_counter.sv | 18 +
 rtl/glb_load_scheduler.sv | 80 ++++++++
 4 files changed

// File: rtl/glb_load_pkg.sv
// glb_load_pkg: shared widths, depths, FSM states and section ordering for the GLB load scheduler
package glb_load_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int IFMAP_DEPTH = 32;
  localparam int WEIGHT_DEPTH = 1024;
  localparam int BIAS_DEPTH = 128;
  localparam int IFMAP_AW = 5;
  localparam int WEIGHT_AW = 10;
  localparam int BIAS_AW = 7;
  localparam int CNT_W = WEIGHT_AW + 1;
  localparam int SEC_IFMAP = 0;
  localparam int SEC_WEIGHT = 1;
  localparam int SEC_BIAS = 2;
  localparam logic [IFMAP_AW:0] IFMAP_MAX = (IFMAP_AW + 1)'(IFMAP_DEPTH);
  localparam logic [WEIGHT_AW:0] WEIGHT_MAX = (WEIGHT_AW + 1)'(WEIGHT_DEPTH);
  localparam logic [BIAS_AW:0] BIAS_MAX = (BIAS_AW + 1)'(BIAS_DEPTH);
  typedef enum logic [2:0] {IDLE, LD_IFMAP, LD_WEIGHT, LD_BIAS, LAUNCH, WAIT_DONE} state_t;
  function automatic state_t next_sec(input state_t cur, input logic [2:0] nz);
    return cur == IDLE && nz[SEC_IFMAP] ? LD_IFMAP :
           cur inside {IDLE, LD_IFMAP} && nz[SEC_WEIGHT] ? LD_WEIGHT :
           cur != LD_BIAS && nz[SEC_BIAS] ? LD_BIAS : LAUNCH;
  endfunction
endpackage

// File: rtl/glb_load_scheduler_if.sv
// glb_load_scheduler_if: cfg/start, DRAM beat handshake, SRAM write and compute handshake bundle; GLB_LOAD_CHKSUM_EN adds chksum
interface glb_load_scheduler_if;
  import glb_load_pkg::*;
  logic start;
  logic [IFMAP_AW:0] cfg_ifmap_len;
  logic [WEIGHT_AW:0] cfg_weight_len;
  logic [BIAS_AW:0] cfg_bias_len;
  logic dram_valid;
  logic [DATA_W-1:0] dram_data;
  logic dram_ready;
  logic ifmap_wen;
  logic weight_wen;
  logic bias_wen;
  logic [ADDR_W-1:0] glb_addr;
  logic [DATA_W-1:0] glb_wdata;
  logic compute_start;
  logic compute_done;
  logic busy;
  logic done;
`ifdef GLB_LOAD_CHKSUM_EN
  logic [DATA_W-1:0] chksum;
`endif
  modport slave (
`ifdef GLB_LOAD_CHKSUM_EN
    output chksum,
`endif
    input start, cfg_ifmap_len, cfg_weight_len, cfg_bias_len, dram_valid, dram_data, compute_done,
    output dram_ready, ifmap_wen, weight_wen, bias_wen, glb_addr, glb_wdata, compute_start, busy, done
  );
  modport master (
`ifdef GLB_LOAD_CHKSUM_EN
    input chksum,
`endif
    output start, cfg_ifmap_len, cfg_weight_len, cfg_bias_len, dram_valid, dram_data, compute_done,
    input dram_ready, ifmap_wen, weight_wen, bias_wen, glb_addr, glb_wdata, compute_start, busy, done
  );
endinterface

// File: rtl/glb_section_counter.sv
// glb_section_counter: up-counter cleared on clr, advanced on en, tc flags the last word of limit; ports clk, rst (async active-low), clr, en, limit, count, tc
module glb_section_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         tc
);
  assign tc = count == limit - W'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + W'(1);
endmodule

// File: rtl/glb_load_scheduler.sv
// glb_load_scheduler: loads ifmap/weight/bias GLB SRAMs from a DRAM beat stream then launches compute; ports clk, rst (async active-low), bus (slave modport); GLB_LOAD_CHKSUM_EN adds bus.chksum
module glb_load_scheduler (
  input logic clk,
  input logic rst,
  glb_load_scheduler_if.slave bus
);
  import glb_load_pkg::*;
  state_t state, nxt;
  logic [IFMAP_AW:0] if_len, c_if;
  logic [WEIGHT_AW:0] wt_len, c_wt;
  logic [BIAS_AW:0] bs_len, c_bs;
  logic [CNT_W-1:0] cnt, limit;
  logic [2:0] nz, cfg_nz;
  logic acc, tc, start_acc;
  assign c_if = bus.cfg_ifmap_len > IFMAP_MAX ? IFMAP_MAX : bus.cfg_ifmap_len;
  assign c_wt = bus.cfg_weight_len > WEIGHT_MAX ? WEIGHT_MAX : bus.cfg_weight_len;
  assign c_bs = bus.cfg_bias_len > BIAS_MAX ? BIAS_MAX : bus.cfg_bias_len;
  assign nz = {|bs_len, |wt_len, |if_len};
  assign cfg_nz = {|c_bs, |c_wt, |c_if};
  assign bus.dram_ready = state inside {LD_IFMAP, LD_WEIGHT, LD_BIAS};
  assign bus.busy = state != IDLE;
  assign acc = bus.dram_valid & bus.dram_ready;
  assign start_acc = state == IDLE && bus.start;
  assign limit = state == LD_IFMAP ? CNT_W'(if_len) : state == LD_WEIGHT ? wt_len : CNT_W'(bs_len);
  glb_section_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(acc & tc),
    .en(acc),
    .limit(limit),
    .count(cnt),
    .tc(tc)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.start ? next_sec(IDLE, cfg_nz) : IDLE;
      LD_IFMAP, LD_WEIGHT, LD_BIAS: nxt = acc && tc ? next_sec(state, nz) : state;
      LAUNCH: nxt = WAIT_DONE;
      WAIT_DONE: nxt = bus.compute_done ? IDLE : WAIT_DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      if_len <= '0;
      wt_len <= '0;
      bs_len <= '0;
      bus.ifmap_wen <= 1'b0;
      bus.weight_wen <= 1'b0;
      bus.bias_wen <= 1'b0;
      bus.glb_addr <= '0;
      bus.glb_wdata <= '0;
      bus.compute_start <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= nxt;
      if (start_acc) begin
        if_len <= c_if;
        wt_len <= c_wt;
        bs_len <= c_bs;
      end
      bus.ifmap_wen <= acc && state == LD_IFMAP;
      bus.weight_wen <= acc && state == LD_WEIGHT;
      bus.bias_wen <= acc && state == LD_BIAS;
      if (acc) begin
        bus.glb_addr <= ADDR_W'(cnt);
        bus.glb_wdata <= bus.dram_data;
      end
      bus.compute_start <= state == LAUNCH;
      bus.done <= state == WAIT_DONE && bus.compute_done;
    end
`ifdef GLB_LOAD_CHKSUM_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) bus.chksum <= '0;
    else if (start_acc) bus.chksum <= '0;
    else if (acc) bus.chksum <= bus.chksum ^ bus.dram_data;
`endif
endmodule
